// File: rtl/umi_req_arbiter_if.sv
// UMI request bundle between NREQ requesters and one host request port.
// The slave modport is the arbiter side; the master modport is the requester/host side.
interface umi_req_arbiter_if #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CMD_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 128
) ();
  logic [NREQ-1:0]            in_req_valid;
  logic [NREQ*CMD_WIDTH-1:0]  in_req_cmd;
  logic [NREQ*ADDR_WIDTH-1:0] in_req_dstaddr;
  logic [NREQ*ADDR_WIDTH-1:0] in_req_srcaddr;
  logic [NREQ*DATA_WIDTH-1:0] in_req_data;
  logic [NREQ-1:0]            in_req_ready;
  logic                       out_req_valid;
  logic [CMD_WIDTH-1:0]       out_req_cmd;
  logic [ADDR_WIDTH-1:0]      out_req_dstaddr;
  logic [ADDR_WIDTH-1:0]      out_req_srcaddr;
  logic [DATA_WIDTH-1:0]      out_req_data;
  logic                       out_req_ready;
  logic [NREQ-1:0]            out_grant;

  modport slave (
    input  in_req_valid, in_req_cmd, in_req_dstaddr, in_req_srcaddr, in_req_data,
    input  out_req_ready,
    output in_req_ready,
    output out_req_valid, out_req_cmd, out_req_dstaddr, out_req_srcaddr, out_req_data,
    output out_grant
  );

  modport master (
    output in_req_valid, in_req_cmd, in_req_dstaddr, in_req_srcaddr, in_req_data,
    output out_req_ready,
    input  in_req_ready,
    input  out_req_valid, out_req_cmd, out_req_dstaddr, out_req_srcaddr, out_req_data,
    input  out_grant
  );
endinterface

// File: rtl/umi_req_arbiter.sv
// Round-robin arbiter sharing one registered UMI host request port among NREQ requesters.
// Optional per-requester saturating grant counters: define UMI_REQ_ARBITER_GRANT_CNT_EN.
module umi_req_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CMD_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic              clk,
  input  logic              reset,
  umi_req_arbiter_if.slave  bus
`ifdef UMI_REQ_ARBITER_GRANT_CNT_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  valid_q;
  logic [NREQ-1:0]       grant_q;
  logic [CMD_WIDTH-1:0]  cmd_q, sel_cmd;
  logic [ADDR_WIDTH-1:0] dstaddr_q, sel_dstaddr;
  logic [ADDR_WIDTH-1:0] srcaddr_q, sel_srcaddr;
  logic [DATA_WIDTH-1:0] data_q, sel_data;

  logic                  load;
  logic                  win_found;
  logic [PtrW-1:0]       win_off, win_idx;
  logic [PtrW:0]         win_sum, nxt_sum;
  logic [NREQ-1:0]       win_oh;
  logic [2*NREQ-1:0]     dbl_valid;
  logic [NREQ-1:0]       rot_valid;

  assign load = !valid_q || bus.out_req_ready;

  // Rotate valids so bit 0 is the requester at ptr; the lowest set bit is the winner offset.
  always_comb begin
    dbl_valid = {bus.in_req_valid, bus.in_req_valid};
    rot_valid = NREQ'(dbl_valid >> ptr_q);
    win_found = |rot_valid;
    win_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) win_off = PtrW'(i);
    end
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    win_idx = (win_sum >= (PtrW+1)'(NREQ)) ? PtrW'(win_sum - (PtrW+1)'(NREQ))
                                           : win_sum[PtrW-1:0];
    win_oh  = win_found ? (NREQ'(1) << win_idx) : '0;
    nxt_sum = {1'b0, win_idx} + (PtrW+1)'(1);
    ptr_d   = (nxt_sum >= (PtrW+1)'(NREQ)) ? '0 : nxt_sum[PtrW-1:0];
  end

  always_comb begin
    sel_cmd     = '0;
    sel_dstaddr = '0;
    sel_srcaddr = '0;
    sel_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_cmd     = bus.in_req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        sel_dstaddr = bus.in_req_dstaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_srcaddr = bus.in_req_srcaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data    = bus.in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Combinational out_req_ready -> in_req_ready path; integrators must account for it.
  assign bus.in_req_ready = load ? win_oh : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
      cmd_q     <= '0;
      dstaddr_q <= '0;
      srcaddr_q <= '0;
      data_q    <= '0;
    end else if (load) begin
      valid_q <= win_found;
      grant_q <= win_oh;
      if (win_found) begin
        ptr_q     <= ptr_d;
        cmd_q     <= sel_cmd;
        dstaddr_q <= sel_dstaddr;
        srcaddr_q <= sel_srcaddr;
        data_q    <= sel_data;
      end
    end
  end

  assign bus.out_req_valid   = valid_q;
  assign bus.out_grant       = grant_q;
  assign bus.out_req_cmd     = cmd_q;
  assign bus.out_req_dstaddr = dstaddr_q;
  assign bus.out_req_srcaddr = srcaddr_q;
  assign bus.out_req_data    = data_q;

`ifdef UMI_REQ_ARBITER_GRANT_CNT_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (load && win_oh[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Self-checking bench for umi_req_arbiter: directed steps plus random traffic against a
// scan-and-capture reference model; covers the grant counters when the macro is defined.
module tb_umi_req_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 32;
  localparam int unsigned AW   = 64;
  localparam int unsigned DW   = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  umi_req_arbiter_if #(
    .NREQ(NREQ), .CMD_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

`ifdef UMI_REQ_ARBITER_GRANT_CNT_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  umi_req_arbiter #(
    .NREQ(NREQ), .CMD_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef UMI_REQ_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Stimulus
  logic [NREQ-1:0] s_valid;
  logic [CW-1:0]   s_cmd  [NREQ];
  logic [AW-1:0]   s_dst  [NREQ];
  logic [AW-1:0]   s_src  [NREQ];
  logic [DW-1:0]   s_data [NREQ];
  logic            s_ready;

  // Reference model: held beat plus round-robin start index
  int            m_ptr;
  bit            m_valid;
  int            m_who;
  logic [CW-1:0] m_cmd;
  logic [AW-1:0] m_dst, m_src;
  logic [DW-1:0] m_data;
  int            m_cnt [NREQ];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.in_req_valid  = s_valid;
    bus.out_req_ready = s_ready;
    for (int i = 0; i < NREQ; i++) begin
      bus.in_req_cmd[i*CW +: CW]     = s_cmd[i];
      bus.in_req_dstaddr[i*AW +: AW] = s_dst[i];
      bus.in_req_srcaddr[i*AW +: AW] = s_src[i];
      bus.in_req_data[i*DW +: DW]    = s_data[i];
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NREQ; i++) begin
      s_cmd[i]  = $urandom;
      s_dst[i]  = {$urandom, $urandom};
      s_src[i]  = {$urandom, $urandom};
      s_data[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (s_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [NREQ-1:0] exp_g;
    exp_g = m_valid ? (NREQ'(1) << m_who) : '0;
    check("out_req_valid", bus.out_req_valid, m_valid);
    check("out_grant", bus.out_grant, exp_g);
    if (m_valid) begin
      check("out_req_cmd", bus.out_req_cmd, m_cmd);
      check("out_req_dstaddr", bus.out_req_dstaddr, m_dst);
      check("out_req_srcaddr", bus.out_req_srcaddr, m_src);
      check("out_req_data", bus.out_req_data, m_data);
    end
  endtask

  // Entered and left at posedge+1; inputs set by the caller beforehand.
  task automatic cycle(input bit chk);
    int              w;
    bit              load;
    logic [NREQ-1:0] exp_rdy;
    apply();
    #1;
    load    = !m_valid || s_ready;
    w       = model_winner();
    exp_rdy = (load && w >= 0) ? (NREQ'(1) << w) : '0;
    if (chk) check("in_req_ready", bus.in_req_ready, exp_rdy);
    @(posedge clk);
    if (load) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_who   = w;
        m_cmd   = s_cmd[w];
        m_dst   = s_dst[w];
        m_src   = s_src[w];
        m_data  = s_data[w];
        m_ptr   = (w + 1) % NREQ;
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (chk) check_outputs();
  endtask

  // Asserts reset between clock edges and checks the outputs clear with no edge.
  task automatic do_reset();
    #1;
    reset   = 1'b1;
    s_valid = '0;
    s_ready = 1'b0;
    apply();
    #1;
    check("rst_out_req_valid", bus.out_req_valid, 1'b0);
    check("rst_out_grant", bus.out_grant, '0);
    check("rst_out_req_cmd", bus.out_req_cmd, '0);
    check("rst_out_req_data", bus.out_req_data, '0);
    m_ptr   = 0;
    m_valid = 1'b0;
    m_who   = 0;
    m_cmd   = '0;
    m_dst   = '0;
    m_src   = '0;
    m_data  = '0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

`ifdef UMI_REQ_ARBITER_GRANT_CNT_EN
  task automatic check_cnt();
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("grant_cnt[%0d]", i), grant_cnt[i*16 +: 16], m_cnt[i][15:0]);
    end
  endtask
`endif

  initial begin
    rand_payload();
    do_reset();

    // Idle after reset
    for (int c = 0; c < 10; c++) cycle(1'b1);

    // Single requester 2
    s_cmd[2]  = 32'h5;
    s_dst[2]  = 64'h100_0000;
    s_data[2] = 128'h48;
    s_valid   = 4'b0100;
    s_ready   = 1'b1;
    cycle(1'b1);
    check("single_grant", bus.out_grant, 4'b0100);
    check("single_data", bus.out_req_data, 128'h48);
    s_valid = '0;
    cycle(1'b1);

    // All valid, downstream always ready: rotation from a fresh pointer
    do_reset();
    s_valid = '1;
    s_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      rand_payload();
      cycle(1'b1);
      check("rotate_grant", bus.out_grant, NREQ'(1) << (c % NREQ));
    end

    // Requesters 1 and 3 with a five-cycle downstream stall
    do_reset();
    s_valid = 4'b1010;
    rand_payload();
    cycle(1'b1);
    check("stall_first", bus.out_grant, 4'b0010);
    s_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_payload();
      cycle(1'b1);
    end
    s_ready = 1'b1;
    cycle(1'b1);
    check("stall_release", bus.out_grant, 4'b1000);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      s_valid = NREQ'($urandom);
      s_ready = ($urandom_range(0, 3) != 0);
      rand_payload();
      cycle(1'b1);
    end
`ifdef UMI_REQ_ARBITER_GRANT_CNT_EN
    check_cnt();
`endif

    // Asynchronous reset while a beat is stalled
    s_valid = '1;
    s_ready = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    check("pre_areset_valid", bus.out_req_valid, 1'b1);
    do_reset();
    s_valid = '1;
    s_ready = 1'b1;
    cycle(1'b1);
    check("post_areset_grant", bus.out_grant, 4'b0001);

`ifdef UMI_REQ_ARBITER_GRANT_CNT_EN
    // Saturate requester 0's counter
    do_reset();
    s_valid = 4'b0001;
    s_ready = 1'b1;
    for (int c = 0; c < 70000; c++) cycle(1'b0);
    check("grant_cnt0_sat", grant_cnt[15:0], 16'hFFFF);
    check_cnt();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/umi_req_arbiter.md
Name: umi_req_arbiter

Overview:
- Round-robin arbiter that shares one UMI host request port among NREQ requesters.
- Example use: several print/test engines, each a putc source, feeding the single host link into the emulation infrastructure.
- A one-deep registered output stage holds the winning transaction until the downstream port accepts it.
- Sustains one transaction per cycle when downstream is always ready.

Parameters:
NREQ, 4, number of requesters (≥1)
CMD_WIDTH, 32, UMI command width
ADDR_WIDTH, 64, UMI address width
DATA_WIDTH, 128, UMI data width

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_req_valid  input  NREQ  per-requester valid
in_req_cmd  input  NREQ*CMD_WIDTH  flattened; requester i at [i*CMD_WIDTH +: CMD_WIDTH]
in_req_dstaddr  input  NREQ*ADDR_WIDTH  flattened, same packing
in_req_srcaddr  input  NREQ*ADDR_WIDTH  flattened, same packing
in_req_data  input  NREQ*DATA_WIDTH  flattened, same packing
in_req_ready  output  NREQ  per-requester ready
out_req_valid  output  1  registered valid to UMI host port
out_req_cmd  output  CMD_WIDTH  registered
out_req_dstaddr  output  ADDR_WIDTH  registered
out_req_srcaddr  output  ADDR_WIDTH  registered
out_req_data  output  DATA_WIDTH  registered
out_req_ready  input  1  downstream ready
out_grant  output  NREQ  one-hot source of the beat held in the output register; 0 when empty

Behaviour:
- Reset (async assert, sync release):
  - out_req_valid=0; cmd/dstaddr/srcaddr/data=0; out_grant=0; rr pointer=0.
  - Any held beat is discarded.
- load = !out_req_valid || out_req_ready (combinational).
- Winner selection (combinational):
  - Scan requesters from index ptr upward, wrapping modulo NREQ.
  - The first i with in_req_valid[i]=1 wins.
  - No valid requester means no winner.
- in_req_ready[i] = load && winner==i.
  - At most one bit set per cycle.
  - This creates a combinational path out_req_ready -> in_req_ready; it is allowed and must be documented at integration.
- Accept (load && winner exists), at the next edge:
  - Output registers capture the winner's cmd/dstaddr/srcaddr/data.
  - out_req_valid<=1; out_grant<=onehot(winner); ptr<=(winner+1) mod NREQ.
- load && no winner: out_req_valid<=0, out_grant<=0. Data registers hold their previous value (don't-care).
- !load (stall): all output registers and ptr hold; out_req_* stable while valid && !ready (UMI rule).
- Latency: input handshake to out_req_valid is exactly 1 cycle.
- Throughput: 1 beat/cycle with out_req_ready held high; back-to-back grants rotate through the valid requesters.
- Fairness: a requester that keeps valid high is granted within NREQ accepts.
- Simultaneous events: the downstream handshake and a new accept in the same cycle are legal. The output register is overwritten with the new winner with no bubble.
- NREQ=1: the arbiter degenerates to a pipeline register; ptr is constant 0.
- Requester dropping valid without a handshake: tolerated; the arbiter only samples a requester in the cycle it is granted.
- No transaction reordering within a requester; no merging or splitting of beats.

Optional Feature:
- Macro: UMI_REQ_ARBITER_GRANT_CNT_EN.
- Defined:
  - Extra output port grant_cnt, NREQ*16 bits, flattened per requester.
  - Counter i increments by 1 on each accept from requester i and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, all in_req_valid=0 for 10 cycles -> out_req_valid=0, out_grant=0, in_req_ready=0 throughout.
- Single requester 2 sends cmd=0x5, dstaddr=0x1000000, data=0x48, out_req_ready=1 -> in_req_ready[2] high that cycle; next cycle out_req_valid=1, out_grant=4'b0100, data=0x48.
- All 4 requesters valid continuously, out_req_ready=1 -> out_grant sequence 0001, 0010, 0100, 1000, 0001…; one beat per cycle, no bubbles.
- Requesters 1 and 3 valid, out_req_ready held 0 for 5 cycles after first capture -> out_req_* stable, in_req_ready=0 during stall; release -> requester 3 granted next (ptr=2 after granting 1).
- Assert reset asynchronously while out_req_valid=1 and out_req_ready=0 -> out_req_valid drops to 0 immediately without a clock edge; after release ptr=0, so requester 0 wins first if all valid.
- With UMI_REQ_ARBITER_GRANT_CNT_EN: requester 0 alone sends 70000 beats -> its grant_cnt reads 0xFFFF (saturated); other counters read 0.
